// File: rtl/demux32_1to4_stream_if.sv
// Stream bundle for the 1:4 word demux: one upstream port, four downstream slots.
// Count lanes exist only when DEMUX_CNT_EN is defined.
interface demux32_1to4_stream_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]      in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            sel;
    logic [3:0][WIDTH-1:0] out_data;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
`ifdef DEMUX_CNT_EN
    logic [3:0][15:0]      count;
`endif

    modport master (
        output in_data, in_valid, sel, out_ready,
`ifdef DEMUX_CNT_EN
        input  count,
`endif
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
`ifdef DEMUX_CNT_EN
        output count,
`endif
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux32_1to4_stream.sv
// Routes one word stream to four destinations, each with a one-entry holding slot.
// Define DEMUX_CNT_EN to add per-slot 16-bit delivered-word counters.
module demux32_1to4_stream #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    demux32_1to4_stream_if.slave    bus
);
    logic [3:0]            valid_q;
    logic [3:0][WIDTH-1:0] data_q;
    logic [3:0]            deliver;
    logic [3:0]            load;
    logic                  accept;

    // A full slot can be refilled in the same cycle it drains.
    always_comb begin
        deliver = valid_q & bus.out_ready;
        accept  = rst && (!valid_q[bus.sel] || bus.out_ready[bus.sel]);
        load    = '0;
        if (bus.in_valid && accept) begin
            load[bus.sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k]  <= bus.in_data;
                    valid_q[k] <= 1'b1;
                end else if (deliver[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = accept;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;

`ifdef DEMUX_CNT_EN
    logic [3:0][15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (deliver[k]) begin
                    cnt_q[k] <= cnt_q[k] + 16'd1;
                end
            end
        end
    end

    assign bus.count = cnt_q;
`endif
endmodule

// File: tb/tb_demux32_1to4_stream.sv
// Bench for demux32_1to4_stream: directed vector table, reset corner, random run vs queue model.
// Counter checks are compiled in when DEMUX_CNT_EN is defined.
module tb_demux32_1to4_stream;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    demux32_1to4_stream_if #(.WIDTH(32)) bus ();

    demux32_1to4_stream #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         rst;
        logic         iv;
        logic [1:0]   sel;
        logic [31:0]  din;
        logic [3:0]   rdy;
        logic         chk;
        logic         exp_rdy;
        logic [3:0]   exp_valid;
        logic [127:0] exp_out;
    } vec_t;

    vec_t vecs [20];

    logic [31:0] mq [4][$];
    logic [15:0] mcnt [4];

    function automatic vec_t mk(logic r, logic iv, logic [1:0] s, logic [31:0] d, logic [3:0] rdy,
                                logic chk, logic er, logic [3:0] ev,
                                logic [31:0] o3, logic [31:0] o2, logic [31:0] o1, logic [31:0] o0);
        vec_t v;
        v.rst = r; v.iv = iv; v.sel = s; v.din = d; v.rdy = rdy;
        v.chk = chk; v.exp_rdy = er; v.exp_valid = ev;
        v.exp_out = {o3, o2, o1, o0};
        return v;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic iv, logic [1:0] s, logic [31:0] d, logic [3:0] rdy);
        rst           = r;
        bus.in_valid  = iv;
        bus.sel       = s;
        bus.in_data   = d;
        bus.out_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle();
        logic       r;
        logic       iv;
        logic [1:0] s;
        logic [3:0] rdy;
        logic       exp_rdy;
        logic [3:0] dlv;
        logic       xfer;
        r   = ($urandom_range(0, 63) != 0);
        iv  = ($urandom_range(0, 3) != 0);
        s   = 2'($urandom_range(0, 3));
        rdy = 4'($urandom_range(0, 15));
        drive(r, iv, s, $urandom, rdy);
        @(negedge clk);
        exp_rdy = r && (mq[s].size() == 0 || rdy[s]);
        check("rand_in_ready", 128'(bus.in_ready), 128'(exp_rdy));
        for (int k = 0; k < 4; k++) begin
            check("rand_out_valid", 128'(bus.out_valid[k]), 128'(mq[k].size() != 0));
            if (mq[k].size() != 0)
                check("rand_out_data", 128'(bus.out_data[k]), 128'(mq[k][0]));
`ifdef DEMUX_CNT_EN
            check("rand_count", 128'(bus.count[k]), 128'(mcnt[k]));
`endif
            dlv[k] = (mq[k].size() != 0) && rdy[k];
        end
        xfer = iv && exp_rdy;
        next_cycle();
        if (!r) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                mcnt[k] = '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (dlv[k]) begin
                    void'(mq[k].pop_front());
                    mcnt[k] = mcnt[k] + 16'd1;
                end
            end
            if (xfer) mq[s].push_back(bus.in_data);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b0, 1'b0, 2'd0, 32'd0, 4'hF);

        vecs[0]  = mk(0, 0, 0, 32'h0,        4'hF, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0,  32'h0);
        vecs[1]  = mk(0, 0, 0, 32'h0,        4'hF, 1, 0, 4'h0, 32'h0,  32'h0,        32'h0,  32'h0);
        vecs[2]  = mk(1, 0, 0, 32'h0,        4'hF, 1, 1, 4'h0, 32'h0,  32'h0,        32'h0,  32'h0);
        vecs[3]  = mk(1, 1, 2, 32'hDEADBEEF, 4'h0, 1, 1, 4'h0, 32'h0,  32'h0,        32'h0,  32'h0);
        vecs[4]  = mk(1, 0, 0, 32'h0,        4'h4, 1, 1, 4'h4, 32'h0,  32'hDEADBEEF, 32'h0,  32'h0);
        vecs[5]  = mk(1, 0, 0, 32'h0,        4'h0, 1, 1, 4'h0, 32'h0,  32'hDEADBEEF, 32'h0,  32'h0);
        vecs[6]  = mk(1, 1, 1, 32'h11,       4'h0, 1, 1, 4'h0, 32'h0,  32'hDEADBEEF, 32'h0,  32'h0);
        vecs[7]  = mk(1, 1, 1, 32'h22,       4'h0, 1, 0, 4'h2, 32'h0,  32'hDEADBEEF, 32'h11, 32'h0);
        vecs[8]  = mk(1, 1, 1, 32'h22,       4'h0, 1, 0, 4'h2, 32'h0,  32'hDEADBEEF, 32'h11, 32'h0);
        vecs[9]  = mk(1, 1, 3, 32'h33,       4'h0, 1, 1, 4'h2, 32'h0,  32'hDEADBEEF, 32'h11, 32'h0);
        vecs[10] = mk(1, 1, 1, 32'h22,       4'h2, 1, 1, 4'hA, 32'h33, 32'hDEADBEEF, 32'h11, 32'h0);
        vecs[11] = mk(1, 0, 0, 32'h0,        4'h0, 1, 1, 4'hA, 32'h33, 32'hDEADBEEF, 32'h22, 32'h0);
        vecs[12] = mk(1, 0, 0, 32'h0,        4'hF, 1, 1, 4'hA, 32'h33, 32'hDEADBEEF, 32'h22, 32'h0);
        vecs[13] = mk(1, 0, 0, 32'h0,        4'hF, 1, 1, 4'h0, 32'h33, 32'hDEADBEEF, 32'h22, 32'h0);
        vecs[14] = mk(1, 1, 0, 32'h1,        4'h1, 1, 1, 4'h0, 32'h33, 32'hDEADBEEF, 32'h22, 32'h0);
        vecs[15] = mk(1, 1, 0, 32'h2,        4'h1, 1, 1, 4'h1, 32'h33, 32'hDEADBEEF, 32'h22, 32'h1);
        vecs[16] = mk(1, 1, 0, 32'h3,        4'h1, 1, 1, 4'h1, 32'h33, 32'hDEADBEEF, 32'h22, 32'h2);
        vecs[17] = mk(1, 1, 0, 32'h4,        4'h1, 1, 1, 4'h1, 32'h33, 32'hDEADBEEF, 32'h22, 32'h3);
        vecs[18] = mk(1, 0, 0, 32'h0,        4'h1, 1, 1, 4'h1, 32'h33, 32'hDEADBEEF, 32'h22, 32'h4);
        vecs[19] = mk(1, 0, 0, 32'h0,        4'h1, 1, 1, 4'h0, 32'h33, 32'hDEADBEEF, 32'h22, 32'h4);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].din, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), 128'(bus.in_ready), 128'(vecs[i].exp_rdy));
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_valid", i), 128'(bus.out_valid), 128'(vecs[i].exp_valid));
                check($sformatf("vec%0d_out", i), 128'(bus.out_data), vecs[i].exp_out);
            end
            next_cycle();
        end

        // Reset while slot 2 holds a stalled word: the word is dropped.
        drive(1'b1, 1'b1, 2'd2, 32'h55, 4'h0);
        next_cycle();
        drive(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
        @(negedge clk);
        check("mid_valid_before", 128'(bus.out_valid), 128'(4'h4));
        check("mid_out2_before", 128'(bus.out_data[2]), 128'(32'h55));
        next_cycle();
        drive(1'b0, 1'b1, 2'd1, 32'h66, 4'h0);
        @(negedge clk);
        check("mid_in_ready_rst", 128'(bus.in_ready), 128'(1'b0));
        next_cycle();
        drive(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
        @(negedge clk);
        check("mid_valid_after", 128'(bus.out_valid), 128'(4'h0));
        check("mid_out_after", 128'(bus.out_data), 128'(0));
        check("mid_in_ready_after", 128'(bus.in_ready), 128'(1'b1));
`ifdef DEMUX_CNT_EN
        check("mid_count_after", 128'(bus.count), 128'(0));
`endif
        next_cycle();

        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mcnt[k] = '0;
        end
        for (int n = 0; n < 1500; n++) rand_cycle();

`ifdef DEMUX_CNT_EN
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        next_cycle();
        for (int n = 0; n < 65535; n++) begin
            drive(1'b1, 1'b1, 2'd0, 32'(n), 4'hF);
            next_cycle();
        end
        drive(1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        next_cycle();
        @(negedge clk);
        check("cnt0_ffff", 128'(bus.count[0]), 128'(16'hFFFF));
        check("cnt_others_zero", 128'(bus.count[3:1]), 128'(0));
        drive(1'b1, 1'b1, 2'd0, 32'h77, 4'hF);
        next_cycle();
        drive(1'b1, 1'b1, 2'd1, 32'h88, 4'hF);
        next_cycle();
        drive(1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        next_cycle();
        @(negedge clk);
        check("cnt0_wrap", 128'(bus.count[0]), 128'(16'h0000));
        check("cnt1_one", 128'(bus.count[1]), 128'(16'h0001));
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        next_cycle();
        drive(1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        @(negedge clk);
        check("cnt_reset", 128'(bus.count), 128'(0));
        next_cycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
